// File: rtl/mips_step_controller.sv
// mips_step_controller: paces cpu_clk tick pulses (core clock enable) for the MIPS
// test core. It supports single step, fixed-length burst and free run, all derived
// from the 50 MHz board clock.
// Optional PC breakpoint: define MIPS_STEP_BREAKPOINT_EN.
module mips_step_controller #(
    parameter int unsigned RUN_DIV = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_50MHz,
    input  logic             reset_n,
    input  logic             step_req,
    input  logic             burst_req,
    input  logic             run_req,
    input  logic [7:0]       burst_len,
    input  logic [7:0]       pc_lsb,
    input  logic [7:0]       bp_addr,
    input  logic             bp_arm,
    output logic             cpu_clk,
    output logic             busy,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] tick_count,
    output logic             bp_hit
);

    localparam int unsigned DIV_W = $clog2(RUN_DIV);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StBurst = 2'd2,
        StHalt  = 2'd3
    } state_e;

    state_e           state_q;
    logic [DIV_W-1:0] div_q;
    logic [7:0]       rem_q;
    logic             cpu_clk_q;
    logic [CNT_W-1:0] tick_count_q;
    logic             skip_bp_q;

    logic tick_due;
    logic burst_ok;
    logic bp_match;

    // Divider counts down modulo RUN_DIV; the tick is registered one cycle after
    // div_q reaches 1, so the first tick lands RUN_DIV cycles after the request.
    assign tick_due = (div_q == DIV_W'(1));
    assign burst_ok = burst_req && (burst_len != 8'd0);

`ifdef MIPS_STEP_BREAKPOINT_EN
    assign bp_match = bp_arm && (pc_lsb == bp_addr) && !skip_bp_q;
`else
    logic unused_bp;
    assign unused_bp = ^{pc_lsb, bp_addr, bp_arm, skip_bp_q};
    assign bp_match  = 1'b0;
`endif

    // Sequencer FSM with registered tick pulse, divider, burst count and counter.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            div_q        <= '0;
            rem_q        <= 8'd0;
            cpu_clk_q    <= 1'b0;
            tick_count_q <= '0;
            skip_bp_q    <= 1'b0;
        end else begin
            cpu_clk_q <= 1'b0;
            case (state_q)
                StIdle, StHalt: begin
                    if (run_req) begin
                        state_q   <= StRun;
                        div_q     <= DIV_W'(RUN_DIV - 1);
                        rem_q     <= 8'd0;
                        skip_bp_q <= (state_q == StHalt);
                    end else if (burst_ok) begin
                        state_q   <= StBurst;
                        div_q     <= DIV_W'(RUN_DIV - 1);
                        rem_q     <= burst_len;
                        skip_bp_q <= (state_q == StHalt);
                    end else if (step_req && !cpu_clk_q) begin
                        // Guard on cpu_clk_q keeps back-to-back steps from merging pulses.
                        state_q      <= StIdle;
                        rem_q        <= 8'd0;
                        cpu_clk_q    <= 1'b1;
                        tick_count_q <= tick_count_q + CNT_W'(1);
                    end
                end
                StRun, StBurst: begin
                    if (run_req) begin
                        // Stop wins over a tick falling due in the same cycle.
                        state_q <= StIdle;
                        rem_q   <= 8'd0;
                    end else if ((state_q == StBurst) && (rem_q == 8'd0)) begin
                        state_q <= StIdle;
                    end else begin
                        div_q <= (div_q == '0) ? DIV_W'(RUN_DIV - 1) : div_q - DIV_W'(1);
                        if (tick_due) begin
                            if (bp_match) begin
                                // Remaining burst count is kept but unused after HALT.
                                state_q <= StHalt;
                            end else begin
                                cpu_clk_q    <= 1'b1;
                                tick_count_q <= tick_count_q + CNT_W'(1);
                                skip_bp_q    <= 1'b0;
                                if (state_q == StBurst) begin
                                    rem_q <= rem_q - 8'd1;
                                end
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cpu_clk    = cpu_clk_q;
    assign busy       = (state_q == StRun) || (state_q == StBurst);
    assign state      = state_q;
    assign tick_count = tick_count_q;
    assign bp_hit     = (state_q == StHalt);

endmodule

// File: tb/tb_mips_step_controller.sv
// Self-checking bench for mips_step_controller (RUN_DIV=4). The counter is built
// 8 bits wide so the wrap check stays short; the breakpoint scenario adapts to
// MIPS_STEP_BREAKPOINT_EN.
module tb_mips_step_controller;

    localparam int unsigned RUN_DIV = 4;
    localparam int unsigned CNT_W   = 8;

    logic             clk_50MHz = 1'b0;
    logic             reset_n;
    logic             step_req, burst_req, run_req;
    logic [7:0]       burst_len;
    logic [7:0]       pc;
    logic [7:0]       bp_addr;
    logic             bp_arm;
    logic             cpu_clk, busy, bp_hit;
    logic [1:0]       state;
    logic [CNT_W-1:0] tick_count;

    int n_checks = 0;
    int n_fail   = 0;

    mips_step_controller #(.RUN_DIV(RUN_DIV), .CNT_W(CNT_W)) dut (
        .clk_50MHz  (clk_50MHz),
        .reset_n    (reset_n),
        .step_req   (step_req),
        .burst_req  (burst_req),
        .run_req    (run_req),
        .burst_len  (burst_len),
        .pc_lsb     (pc),
        .bp_addr    (bp_addr),
        .bp_arm     (bp_arm),
        .cpu_clk    (cpu_clk),
        .busy       (busy),
        .state      (state),
        .tick_count (tick_count),
        .bp_hit     (bp_hit)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    // Core PC model: advances one instruction per tick.
    always @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) pc <= 8'h00;
        else if (cpu_clk) pc <= pc + 8'h04;
    end

    typedef struct {
        logic        step;
        logic        burst;
        logic        run;
        logic [7:0]  len;
        logic        exp_clk;
        logic        exp_busy;
        logic [1:0]  exp_state;
        int unsigned exp_cnt;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic s, input logic b, input logic r,
                                input logic [7:0] l, input logic c, input logic bz,
                                input logic [1:0] st, input int unsigned cnt);
        vec_t v;
        v.step = s; v.burst = b; v.run = r; v.len = l;
        v.exp_clk = c; v.exp_busy = bz; v.exp_state = st; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        step_req = 1'b0; burst_req = 1'b0; run_req = 1'b0; burst_len = 8'd0;
    endtask

    // Drive a request for one cycle; returns 1 ns into the following cycle.
    task automatic issue(input logic s, input logic b, input logic r, input logic [7:0] l);
        step_req = s; burst_req = b; run_req = r; burst_len = l;
        @(posedge clk_50MHz); #1;
        clear_inputs();
    endtask

    task automatic idle_cycle();
        @(posedge clk_50MHz); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #25;
        reset_n = 1'b1;
        idle_cycle();
    endtask

    initial begin
        int ticks;
        int extra;
        int k;
        logic [7:0] pc_exp;

        reset_n = 1'b0;
        clear_inputs();
        bp_arm  = 1'b0;
        bp_addr = 8'h00;
        #25;
        check("reset cpu_clk", 32'(cpu_clk), 0);
        check("reset busy", 32'(busy), 0);
        check("reset state", 32'(state), 0);
        check("reset tick_count", 32'(tick_count), 0);
        check("reset bp_hit", 32'(bp_hit), 0);
        @(negedge clk_50MHz) reset_n = 1'b1;
        idle_cycle();
        check("no tick after reset", 32'(cpu_clk), 0);

        // Cycle-level vectors: inputs in one cycle, outputs expected in the next.
        vecs[0]  = mk(1, 0, 0, 8'd0, 1, 0, 2'd0, 1);  // step
        vecs[1]  = mk(0, 0, 0, 8'd0, 0, 0, 2'd0, 1);
        vecs[2]  = mk(1, 0, 1, 8'd0, 0, 1, 2'd1, 1);  // run beats step
        vecs[3]  = mk(0, 0, 0, 8'd0, 0, 1, 2'd1, 1);
        vecs[4]  = mk(0, 0, 0, 8'd0, 0, 1, 2'd1, 1);
        vecs[5]  = mk(0, 0, 0, 8'd0, 1, 1, 2'd1, 2);  // first run tick at N+4
        vecs[6]  = mk(0, 0, 1, 8'd0, 0, 0, 2'd0, 2);  // stop
        vecs[7]  = mk(0, 1, 0, 8'd0, 0, 0, 2'd0, 2);  // zero-length burst ignored
        vecs[8]  = mk(0, 1, 0, 8'd2, 0, 1, 2'd2, 2);  // burst of 2
        vecs[9]  = mk(0, 0, 0, 8'd0, 0, 1, 2'd2, 2);
        vecs[10] = mk(0, 0, 0, 8'd0, 0, 1, 2'd2, 2);
        vecs[11] = mk(0, 0, 0, 8'd0, 1, 1, 2'd2, 3);
        vecs[12] = mk(1, 0, 0, 8'd0, 0, 1, 2'd2, 3);  // step ignored while busy
        vecs[13] = mk(0, 0, 0, 8'd0, 0, 1, 2'd2, 3);
        vecs[14] = mk(0, 0, 0, 8'd0, 0, 1, 2'd2, 3);
        vecs[15] = mk(0, 0, 0, 8'd0, 1, 1, 2'd2, 4);  // last burst tick
        vecs[16] = mk(0, 0, 0, 8'd0, 0, 0, 2'd0, 4);  // busy low next cycle
        vecs[17] = mk(1, 0, 0, 8'd0, 1, 0, 2'd0, 5);

        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].step, vecs[i].burst, vecs[i].run, vecs[i].len);
            check($sformatf("vec%0d cpu_clk", i), 32'(cpu_clk), 32'(vecs[i].exp_clk));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d tick_count", i), 32'(tick_count), vecs[i].exp_cnt);
        end
        idle_cycle();

        // Burst of 5: ticks at N+4..N+20, busy drops at N+21.
        issue(0, 1, 0, 8'd5);
        for (int c = 1; c <= 24; c++) begin
            check($sformatf("burst5 tick@N+%0d", c), 32'(cpu_clk),
                  32'((c % 4 == 0) && (c <= 20)));
            if (c == 20) check("burst5 busy@N+20", 32'(busy), 1);
            if (c == 21) check("burst5 busy@N+21", 32'(busy), 0);
            idle_cycle();
        end
        check("burst5 tick_count", 32'(tick_count), 10);
        check("burst5 state", 32'(state), 0);

        // Run, then stop in the cycle after the third tick.
        issue(0, 0, 1, 8'd0);
        ticks = 0;
        for (k = 1; k <= 40; k++) begin
            if (cpu_clk) ticks++;
            if (ticks == 3) break;
            idle_cycle();
        end
        check("run reached 3 ticks", 32'(ticks), 3);
        check("run 3rd tick at N+12", 32'(k), 12);
        idle_cycle();
        issue(0, 0, 1, 8'd0);
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            if (cpu_clk) extra++;
            idle_cycle();
        end
        check("run no ticks after stop", 32'(extra), 0);
        check("run stopped state", 32'(state), 0);
        check("run tick_count", 32'(tick_count), 13);

        // Asynchronous reset in the middle of a run.
        issue(0, 0, 1, 8'd0);
        repeat (5) idle_cycle();
        #5 reset_n = 1'b0;
        #2;
        check("midrst cpu_clk", 32'(cpu_clk), 0);
        check("midrst busy", 32'(busy), 0);
        check("midrst state", 32'(state), 0);
        check("midrst tick_count", 32'(tick_count), 0);
        check("midrst bp_hit", 32'(bp_hit), 0);
        idle_cycle();
        #5 reset_n = 1'b1;
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            idle_cycle();
            if (cpu_clk) extra++;
        end
        check("midrst no ticks after release", 32'(extra), 0);
        check("midrst still idle", 32'(state), 0);

        // Counter wrap: 2^CNT_W - 1 steps, then one more.
        for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
            issue(1, 0, 0, 8'd0);
            idle_cycle();
        end
        check("wrap preset", 32'(tick_count), (1 << CNT_W) - 1);
        issue(1, 0, 0, 8'd0);
        check("wrap tick", 32'(cpu_clk), 1);
        check("wrap to zero", 32'(tick_count), 0);
        idle_cycle();

        // Breakpoint at PC 0x0C with the PC model starting at 0.
        do_reset();
        bp_arm  = 1'b1;
        bp_addr = 8'h0C;
        issue(0, 0, 1, 8'd0);
        ticks = 0;
        for (int c = 1; c <= 24; c++) begin
            if (cpu_clk) ticks++;
            idle_cycle();
        end
`ifdef MIPS_STEP_BREAKPOINT_EN
        check("bp ticks before halt", 32'(ticks), 3);
        check("bp state halt", 32'(state), 3);
        check("bp_hit set", 32'(bp_hit), 1);
        check("bp not busy", 32'(busy), 0);
        pc_exp = 8'h10;
        issue(1, 0, 0, 8'd0);
        check("bp step tick", 32'(cpu_clk), 1);
        idle_cycle();
        check("bp pc after step", 32'(pc), 32'(pc_exp));
        check("bp state after step", 32'(state), 0);
        check("bp_hit cleared", 32'(bp_hit), 0);
`else
        check("nobp ticks continue", 32'(ticks), 6);
        check("nobp state run", 32'(state), 1);
        check("nobp bp_hit low", 32'(bp_hit), 0);
        pc_exp = 8'h18;
        check("nobp pc", 32'(pc), 32'(pc_exp));
        issue(0, 0, 1, 8'd0);
        check("nobp stopped", 32'(state), 0);
`endif
        bp_arm = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
